fft_bin_collector: RTL
======================

Name: fft_bin_collector

Overview:
- Receiving end of the FFT core's output stream: consumes one N-point complex frame per transform (valid/sop/eop handshake plus real/imag words).
- Converts the first N/2 bins to saturated magnitudes and stores them in a ping-pong bin buffer.
- The visualizer's bar renderer reads one complete, stable frame while the next frame is being collected.

Parameters:
- N, 1024, FFT points per frame.
- fp_width, 32, width of the signed real/imag input words.
- mag_width, 9, width of a stored magnitude.
- BINS, N/2, bins stored per frame (addresses 0..BINS-1).
- SHIFT, 16, right shift applied to the raw magnitude before saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- src_valid  in  1  input beat valid.
- src_sop  in  1  first beat of frame.
- src_eop  in  1  last beat of frame.
- src_real  in  fp_width  signed real part.
- src_imag  in  fp_width  signed imaginary part.
- src_ready  out  1  collector accepts beats; a beat transfers when src_valid && src_ready.
- rd_addr  in  $clog2(BINS)  bin address from the renderer.
- rd_data  out  mag_width  magnitude at rd_addr from the published bank.
- frame_ready  out  1  published bank holds a complete frame.
- frame_ack  in  1  one-cycle pulse: renderer releases the published bank.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset values:
  - state IDLE, src_ready=1, frame_ready=0, frame_err=0, rd_data=0.
  - write bank=0, read bank=1, bin counter k=0.
- Magnitude pipeline, 2 stages, no stalls:
  - Stage 1: a=|re|, b=|im|. The most negative input saturates to 2^(fp_width-1)-1.
  - Stage 2: m = max(a,b) + (min(a,b)>>1), computed on fp_width+1 unsigned bits.
  - Stored value is (m>>SHIFT), saturated to 2^mag_width-1.
  - Bin k is written to the write bank 2 cycles after its beat transfers, only when k<BINS. Bins BINS..N-1 are counted but not stored.
- States:
  - IDLE:
    - src_ready=1.
    - A transfer with src_sop=1 is bin 0: k<=1, go to COLLECT.
    - A transfer without sop is ignored.
    - sop and eop together on the same beat: frame_err pulse, stay IDLE.
  - COLLECT:
    - src_ready=1. Each transfer is bin k, then k<=k+1. Cycles with src_valid low hold k.
    - Transfer with eop and k==N-1: go to FLUSH.
    - Transfer with eop and k!=N-1: frame_err pulse, go to IDLE, nothing published.
    - Transfer with k==N-1 and no eop: frame_err pulse, go to IDLE.
    - Transfer with sop: frame_err pulse. The frame restarts and this beat becomes bin 0 (k<=1), staying in COLLECT.
  - FLUSH:
    - Lasts 2 cycles, src_ready=0, letting the last pipelined writes land.
    - On its last cycle, if frame_ready==0 or frame_ack==1: swap banks, frame_ready<=1, go to IDLE.
    - Otherwise go to PEND.
  - PEND:
    - src_ready=0. Waits for frame_ack.
    - On frame_ack: swap banks, frame_ready stays 1, go to IDLE.
- frame_ack rules:
  - Outside a swap cycle, frame_ack with frame_ready=1 clears frame_ready the next cycle.
  - frame_ack with frame_ready=0 is ignored.
  - When a swap and frame_ack coincide, the swap wins: frame_ready=1 and the new bank is visible.
- Read port:
  - rd_data is registered, 1-cycle latency, from the read bank.
  - The read bank never changes except at a swap. rd_data reflects a swap from the cycle after it.
  - Read values are valid only while frame_ready=1.
- Reset mid-frame: any partial frame is discarded and frame_ready drops to 0. Stored bank contents need not be cleared.
- frame_err is never asserted for more than one cycle per error event.

Test Plan:
- Ramp frame:
  - Stimulus: sop at bin 0; bin k has re=k<<16, im=0 for k=0..1023; eop at 1023; src_valid continuous.
  - Response: src_ready low for exactly 2 cycles after the eop beat. frame_ready rises at the end of FLUSH. Reading addresses 0..511 returns 0..511.
- Magnitude and saturation:
  - Bin 5 with re=3<<16, im=-(4<<16) reads 5.
  - Bin 6 with re=32'h8000_0000 reads 511.
  - Bin 7 with re=im=0 reads 0.
- Gapped valid:
  - Stimulus: ramp frame with src_valid low every other cycle.
  - Response: same contents as the ramp frame; frame_ready rises once.
- Early eop and mid-frame sop:
  - eop at k=500: one frame_err pulse, frame_ready stays 0.
  - sop at k=300 followed by a full 1024-beat frame: one frame_err pulse, then a correct publish of the restarted frame.
- Backpressure:
  - Stimulus: publish frame A, withhold frame_ack, send frame B.
  - Response: PEND is entered, src_ready=0, rd_data still shows A.
  - Then frame_ack: B becomes visible the next cycle, frame_ready stays 1, src_ready returns to 1.
- Reset mid-frame:
  - Stimulus: rst at k=200.
  - Response: next cycle src_ready=1, frame_ready=0, frame_err=0. A following full frame publishes correctly.

Source files
------------

// File: rtl/fft_bin_collector.sv
// Collects an N-point FFT output frame, stores the saturated magnitudes of the first N/2 bins in a ping-pong buffer.
// Latency: a bin lands in the write bank 2 cycles after its beat transfers; rd_data follows rd_addr by 1 cycle.
// Backpressure: src_ready drops for the 2-cycle flush and while a finished frame waits for frame_ack (PEND).
module fft_bin_collector #(
    parameter  int N         = 1024,
    parameter  int FP_WIDTH  = 32,
    parameter  int MAG_WIDTH = 9,
    parameter  int SHIFT     = 16,
    localparam int BINS      = N / 2,
    localparam int AW        = $clog2(BINS),
    localparam int KW        = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    input  logic                 src_sop,
    input  logic                 src_eop,
    input  logic [FP_WIDTH-1:0]  src_real,
    input  logic [FP_WIDTH-1:0]  src_imag,
    output logic                 src_ready,
    input  logic [AW-1:0]        rd_addr,
    output logic [MAG_WIDTH-1:0] rd_data,
    output logic                 frame_ready,
    input  logic                 frame_ack,
    output logic                 frame_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, PEND} state_t;

    localparam logic [FP_WIDTH:0] MAG_MAX = {{(FP_WIDTH + 1 - MAG_WIDTH){1'b0}}, {MAG_WIDTH{1'b1}}};

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                flush_q, flush_d;
    logic                wr_bank_q, wr_bank_d;
    logic                frame_ready_q, frame_ready_d;
    logic                frame_err_q, frame_err_d;
    logic                src_ready_q, src_ready_d;

    logic                xfer;
    logic                swap;
    logic                in_frame_beat;
    logic [KW-1:0]       bin_idx;

    logic [FP_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic                s1_we_q, s1_we_d;
    logic [AW-1:0]       s1_addr_q, s1_addr_d;
    logic [MAG_WIDTH-1:0] s2_mag_q, s2_mag_d;
    logic                s2_we_q, s2_we_d;
    logic [AW-1:0]       s2_addr_q, s2_addr_d;
    logic [MAG_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [MAG_WIDTH-1:0] bank_mem [2*BINS];

    // Most negative input has no positive twin, so it clamps to the largest positive value.
    function automatic logic [FP_WIDTH-1:0] sat_abs(input logic signed [FP_WIDTH-1:0] x);
        if (x == {1'b1, {(FP_WIDTH-1){1'b0}}}) return {1'b0, {(FP_WIDTH-1){1'b1}}};
        else if (x[FP_WIDTH-1]) return -x;
        else return x;
    endfunction

    assign xfer        = src_valid && src_ready_q;
    assign src_ready   = src_ready_q;
    assign frame_ready = frame_ready_q;
    assign frame_err   = frame_err_q;
    assign rd_data     = rd_data_q;

    // Frame state machine next-state: framing checks, bin counting, flush and bank hand-over.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        flush_d       = flush_q;
        frame_err_d   = 1'b0;
        swap          = 1'b0;
        in_frame_beat = 1'b0;
        bin_idx       = k_q;
        case (state_q)
            IDLE: begin
                if (xfer && src_sop) begin
                    if (src_eop) begin
                        frame_err_d = 1'b1;
                    end else begin
                        in_frame_beat = 1'b1;
                        bin_idx       = '0;
                        k_d           = KW'(1);
                        state_d       = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    in_frame_beat = 1'b1;
                    if (src_sop) begin
                        // A new sop restarts the frame; this beat is bin 0 of the new one.
                        frame_err_d = 1'b1;
                        bin_idx     = '0;
                        if (src_eop) state_d = IDLE;
                        else         k_d     = KW'(1);
                    end else if (src_eop) begin
                        if (k_q == KW'(N - 1)) begin
                            state_d = FLUSH;
                            flush_d = 1'b0;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else if (k_q == KW'(N - 1)) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_q) begin
                    // Publish now if the renderer holds nothing or is releasing it this cycle.
                    if (!frame_ready_q || frame_ack) begin
                        swap    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end else begin
                    flush_d = 1'b1;
                end
            end
            PEND: begin
                if (frame_ack) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_bank_d     = swap ? ~wr_bank_q : wr_bank_q;
        // A swap overrides a coincident ack: the freshly published bank is what the renderer sees.
        frame_ready_d = swap ? 1'b1 : (frame_ack ? 1'b0 : frame_ready_q);
        src_ready_d   = (state_d == IDLE) || (state_d == COLLECT);
    end

    // Frame control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            flush_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_err_q   <= 1'b0;
            src_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            flush_q       <= flush_d;
            wr_bank_q     <= wr_bank_d;
            frame_ready_q <= frame_ready_d;
            frame_err_q   <= frame_err_d;
            src_ready_q   <= src_ready_d;
        end
    end

    // Magnitude pipeline: stage 1 absolute values, stage 2 max + min/2 approximation, scaled and clamped.
    always_comb begin
        logic [FP_WIDTH-1:0] mx;
        logic [FP_WIDTH-1:0] mn;
        logic [FP_WIDTH:0]   m_sum;
        logic [FP_WIDTH:0]   m_shift;
        s1_a_d    = sat_abs(src_real);
        s1_b_d    = sat_abs(src_imag);
        s1_we_d   = in_frame_beat && (bin_idx < KW'(BINS));
        s1_addr_d = bin_idx[AW-1:0];

        mx        = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
        mn        = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
        m_sum     = {1'b0, mx} + ({1'b0, mn} >> 1);
        m_shift   = m_sum >> SHIFT;
        s2_mag_d  = (m_shift > MAG_MAX) ? {MAG_WIDTH{1'b1}} : m_shift[MAG_WIDTH-1:0];
        s2_we_d   = s1_we_q;
        s2_addr_d = s1_addr_q;

        rd_data_d = bank_mem[{~wr_bank_q, rd_addr}];
    end

    // Pipeline and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_we_q   <= 1'b0;
            s1_addr_q <= '0;
            s2_mag_q  <= '0;
            s2_we_q   <= 1'b0;
            s2_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_we_q   <= s1_we_d;
            s1_addr_q <= s1_addr_d;
            s2_mag_q  <= s2_mag_d;
            s2_we_q   <= s2_we_d;
            s2_addr_q <= s2_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Bin store: both banks in one array, bank select is the top address bit.
    always_ff @(posedge clk) begin
        if (s2_we_q) bank_mem[{wr_bank_q, s2_addr_q}] <= s2_mag_q;
    end

endmodule
